// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display shift sequencer
package display_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // One second per step at a 100 MHz system clock.
  localparam int DEFAULT_TICK_CNT = 100_000_000;

endpackage

// File: rtl/display_shift_sequencer_if.sv
// rtl/display_shift_sequencer_if.sv - control/status bundle between control FSM and sequencer
// Ports (via modports):
//   master: drives start, dir, loop_en, hold, abort; observes status and pulses
//   slave : observes controls; drives toggle, right, left, busy, done, step_idx
interface display_shift_sequencer_if #(
  parameter int STEP_W = 3
);
  logic              start;
  logic              dir;
  logic              loop_en;
  logic              hold;
  logic              abort;
  logic              toggle;
  logic              right;
  logic              left;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_idx;

  modport master (
    output start, dir, loop_en, hold, abort,
    input  toggle, right, left, busy, done, step_idx
  );

  modport slave (
    input  start, dir, loop_en, hold, abort,
    output toggle, right, left, busy, done, step_idx
  );
endinterface

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - per-step tick counter with terminal-count flag
// Ports:
//   clk, rstb : clock, synchronous active-low reset
//   clr       : force count to zero (takes precedence over counting)
//   en        : advance one tick this cycle
//   tc        : count is at TICK_CNT-1 while enabled; counter wraps to 0 on it
module tick_counter
  import display_pkg::*;
#(
  parameter int TICK_CNT = DEFAULT_TICK_CNT,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CNT - 1);

  logic [CNT_W-1:0] count;

  // Gated by en so a held step never reports its terminal count.
  assign tc = en && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_shift_sequencer.sv
// rtl/display_shift_sequencer.sv - timed multi-step shift sequencer with loop, hold and abort
// Ports:
//   clk, rstb : clock, synchronous active-low reset
//   bus       : slave side of display_shift_sequencer_if (controls in, status/pulses out)
module display_shift_sequencer
  import display_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int TICK_CNT  = DEFAULT_TICK_CNT,
  parameter int CNT_W     = 27,
  parameter int STEP_W    = 3
) (
  input  logic                       clk,
  input  logic                       rstb,
  display_shift_sequencer_if.slave   bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t            state, state_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic              dir_q, dir_n;
  logic              right_q, right_n;
  logic              left_q, left_n;
  logic              done_q, done_n;

  logic tc;
  logic cnt_en;
  logic cnt_clr;

  // Counter sits at zero throughout IDLE, so every RUN entry starts a full step.
  assign cnt_en  = (state == ST_RUN) && !bus.hold;
  assign cnt_clr = (state == ST_IDLE) || bus.abort;

  tick_counter #(
    .TICK_CNT (TICK_CNT),
    .CNT_W    (CNT_W)
  ) u_tick_counter (
    .clk  (clk),
    .rstb (rstb),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      step_q  <= '0;
      dir_q   <= DIR_RIGHT;
      right_q <= 1'b0;
      left_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      step_q  <= step_n;
      dir_q   <= dir_n;
      right_q <= right_n;
      left_q  <= left_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step_q;
    dir_n   = dir_q;
    right_n = 1'b0;
    left_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          dir_n   = bus.dir;
          step_n  = '0;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // Abort wins even over a coincident terminal count: no pulses.
          state_n = ST_IDLE;
          step_n  = '0;
        end else if (tc) begin
          // tc is already gated by hold inside the counter.
          right_n = (dir_q == DIR_RIGHT);
          left_n  = (dir_q == DIR_LEFT);
          if (step_q != LAST_STEP) begin
            step_n = step_q + STEP_W'(1);
          end else if (bus.loop_en) begin
            step_n = '0;
          end else begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
            step_n  = '0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        step_n  = '0;
      end
    endcase
  end

  // toggle/busy are decodes of the state flop, so they stay glitch-free and
  // fall on the same cycle as the final shift pulse.
  assign bus.toggle   = (state == ST_RUN);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.right    = right_q;
  assign bus.left     = left_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step_q;

endmodule

// File: tb/tb_display_shift_sequencer.sv
// tb/tb_display_shift_sequencer.sv - randomized self-checking bench for display_shift_sequencer
module tb_display_shift_sequencer;

  localparam int TICK   = 5;
  localparam int NUM    = 4;
  localparam int CNT_W  = 3;
  localparam int STEP_W = 3;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  display_shift_sequencer_if #(.STEP_W(STEP_W)) bus ();

  display_shift_sequencer #(
    .NUM_STEPS (NUM),
    .TICK_CNT  (TICK),
    .CNT_W     (CNT_W),
    .STEP_W    (STEP_W)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  // Reference: "running", ticks elapsed in the current step, step number,
  // latched direction, and the pulse outputs expected for the coming cycle.
  bit m_run, m_dir, m_right, m_left, m_done;
  int m_el, m_step;

  task automatic model_update();
    m_right = 0; m_left = 0; m_done = 0;
    if (!rstb) begin
      m_run = 0; m_el = 0; m_step = 0; m_dir = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_dir = bus.dir; m_el = 0; m_step = 0;
      end
    end else if (bus.abort) begin
      m_run = 0; m_el = 0; m_step = 0;
    end else if (!bus.hold) begin
      m_el++;
      if (m_el == TICK) begin
        m_el = 0;
        if (m_dir) m_left = 1; else m_right = 1;
        if (m_step + 1 < NUM) m_step++;
        else if (bus.loop_en) m_step = 0;
        else begin m_done = 1; m_run = 0; m_step = 0; end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_run, m_right, m_left, m_run, m_done, STEP_W'(m_step)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.toggle, bus.right, bus.left, bus.busy, bus.done, bus.step_idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.dir = 0; bus.loop_en = 0; bus.hold = 0; bus.abort = 0;
  endtask

  task automatic go_idle();
    clear_inputs();
    bus.abort = 1;
    tick();
    bus.abort = 0;
    tick();
  endtask

  task automatic launch(input bit d, input bit lp);
    bus.dir = d; bus.loop_en = lp; bus.start = 1;
    cyc = 0;
    tick();
    bus.start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstb = 0;
    bus.start = 1;
    tick(); tick();
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", dut_vec(), 8'h00);
    end
    bus.start = 0;
    rstb = 1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%b want=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_right();
    int pulses[$];
    int done_cyc = -1;
    int lefts = 0;
    launch(1'b0, 1'b0);
    checks++;
    if (bus.toggle !== 1'b1) begin
      failures++;
      $display("FAIL right_toggle_rise got=%b want=1", bus.toggle);
    end
    for (int i = 0; i < 25; i++) begin
      if (bus.right) pulses.push_back(cyc);
      if (bus.done) done_cyc = cyc;
      if (bus.left) lefts++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL right_cycle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (pulses.size() != NUM || pulses[0] != TICK + 1 || pulses[1] != 2*TICK + 1 ||
        pulses[2] != 3*TICK + 1 || pulses[3] != 4*TICK + 1) begin
      failures++;
      $display("FAIL right_pulse_times got=%p want=6,11,16,21", pulses);
    end
    checks++;
    if (done_cyc != 4*TICK + 1 || lefts != 0) begin
      failures++;
      $display("FAIL right_done got=done@%0d lefts=%0d want=done@21 lefts=0", done_cyc, lefts);
    end
    go_idle();
  endtask

  task automatic test_left_loop();
    bit seen_wrap = 0;
    int dones = 0;
    int prev = 0;
    launch(1'b1, 1'b1);
    for (int i = 0; i < 80 && bus.busy; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL loop_cycle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (prev == NUM-1 && bus.step_idx == 0 && bus.busy) seen_wrap = 1;
      if (bus.done) dones++;
      if (seen_wrap && bus.step_idx == 2) bus.loop_en = 0;
      prev = int'(bus.step_idx);
      tick();
    end
    if (bus.done) dones++;
    checks++;
    if (!seen_wrap || dones != 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL loop_end got=wrap%0d done%0d busy%b want=wrap1 done1 busy0", seen_wrap, dones, bus.busy);
    end
    go_idle();
  endtask

  task automatic test_hold();
    int first = -1;
    launch(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (cyc == 3) bus.hold = 1;
      if (cyc == 6) bus.hold = 0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hold_cycle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      tick();
      if (bus.right && first < 0) first = cyc;
    end
    checks++;
    if (first != TICK + 1 + 3) begin
      failures++;
      $display("FAIL hold_first_pulse got=%0d want=%0d", first, TICK + 4);
    end
    go_idle();
  endtask

  task automatic test_abort_collision();
    launch(1'b0, 1'b0);
    while (cyc < 2*TICK) tick();
    bus.abort = 1;
    tick();
    bus.abort = 0;
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL abort_collision got=%b want=%b", dut_vec(), 8'h00);
    end
    launch(1'b0, 1'b0);
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL abort_restart cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    launch(1'b1, 1'b0);
    while (cyc < 2*TICK + 3) tick();
    rstb = 0;
    bus.start = 1;
    tick();
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got=%b want=%b", dut_vec(), 8'h00);
    end
    tick();
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL reset_start_ignored got=%b want=%b", dut_vec(), 8'h00);
    end
    bus.start = 0;
    rstb = 1;
    tick();
    launch(1'b0, 1'b0);
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_restart cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_ignored_inputs();
    int lows = 0;
    int lefts = 0;
    launch(1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      bus.dir = 1'($urandom);
      bus.start = (cyc < 18) ? 1'($urandom) : 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ignored_cycle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.left) lefts++;
      tick();
    end
    checks++;
    if (lefts != 0) begin
      failures++;
      $display("FAIL ignored_dir got=%0d left pulses want=0", lefts);
    end
    go_idle();
    launch(1'b0, 1'b0);
    bus.start = 1;
    for (int i = 0; i < 30; i++) begin
      if (!bus.toggle) lows++;
      tick();
    end
    checks++;
    if (lows != 1) begin
      failures++;
      $display("FAIL start_held_gap got=%0d low cycles want=1", lows);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.start   = ($urandom_range(0, 7) == 0);
      bus.dir     = 1'($urandom);
      bus.hold    = ($urandom_range(0, 5) == 0);
      bus.abort   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) bus.loop_en = ~bus.loop_en;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || (bus.right && bus.left)) begin
        failures++;
        $display("FAIL random_cycle i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    go_idle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_right();
    test_left_loop();
    test_hold();
    test_abort_collision();
    test_reset_mid();
    test_ignored_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_shift_sequencer.md
Name: display_shift_sequencer

Overview:
Parametrised successor to the single-direction display step controller. It runs a sequence of NUM_STEPS timed steps once start is seen. At the end of each step it emits a one-cycle shift pulse, either right or left as selected. It supports loop mode, hold/pause, abort, and status outputs (busy, done, step index), and sits between the top-level control FSM and the display shift register / LED driver.

Parameters:
NUM_STEPS, 4, steps per sequence (>=1)
TICK_CNT, 100000000, clocks per step (100 MHz -> 1 s); >=2
CNT_W, 27, tick counter width; must satisfy 2^CNT_W >= TICK_CNT
STEP_W, 3, step index width; must satisfy 2^STEP_W >= NUM_STEPS

Ports:
clk  in  1  system clock, rising edge
rstb  in  1  synchronous active-low reset
start  in  1  level/pulse; sampled only in IDLE
dir  in  1  0 = shift right, 1 = shift left; latched at start
loop_en  in  1  live; sampled at the last step's terminal count
hold  in  1  freezes tick counter while high (RUN only)
abort  in  1  terminates the sequence; highest priority after reset
toggle  out  1  high while sequence RUN
right  out  1  one-cycle pulse at end of a step, dir = 0
left  out  1  one-cycle pulse at end of a step, dir = 1
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on normal sequence completion
step_idx  out  STEP_W  current step, 0..NUM_STEPS-1

Behaviour:
- Reset (rstb = 0 at a clk edge): state = IDLE, count = 0, step_idx = 0, dir_q = 0. Outputs toggle, right, left, busy and done are all 0. Reset mid-sequence aborts with no pulses.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE and RUN (one state register, two-valued enum).
- IDLE:
  - start = 1 -> RUN. Latch dir_q <= dir; count <= 0; step_idx <= 0.
  - toggle and busy rise on the next cycle (1-cycle latency).
- RUN, priority order each edge: abort > hold > terminal count > increment.
  - abort = 1 -> IDLE. count and step_idx cleared. No right/left/done pulse, even if terminal count occurs the same cycle.
  - hold = 1 -> count and step_idx frozen, no pulses. Terminal count is deferred until hold drops.
  - count == TICK_CNT-1 -> count <= 0. Pulse right (dir_q = 0) or left (dir_q = 1) for exactly one cycle.
    - If step_idx < NUM_STEPS-1: step_idx += 1, stay in RUN.
    - Else if loop_en = 1: step_idx <= 0, stay in RUN (seamless, no dead cycle).
    - Else: done pulses on the same cycle as the final shift pulse. State returns to IDLE, so toggle and busy fall on that same cycle.
  - Otherwise count += 1.
- First shift pulse is asserted exactly TICK_CNT cycles after toggle rises. Later pulses are TICK_CNT cycles apart, plus any hold cycles.
- start in RUN is ignored. dir changes in RUN are ignored (dir_q is held).
- start held high through completion re-triggers next cycle: IDLE for 1 cycle, then RUN.
- right and left are never high together. done only ever coincides with a shift pulse.
- NUM_STEPS = 1: every terminal count is the final step.

Decomposition:
- Package display_pkg:
  - state enum (ST_IDLE, ST_RUN)
  - DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1
  - default TICK_CNT constant for 100 MHz
- One sub-module, tick_counter:
  - Parameters TICK_CNT, CNT_W.
  - Inputs clk, rstb, clr, en.
  - Output tc (count == TICK_CNT-1 and en).
  - Wraps to 0 on tc.
- The sequencer holds the FSM, step index and output registers.

Test Plan:
(Sim parameters: TICK_CNT = 5, NUM_STEPS = 4.)
1. Single right sequence: start pulse with dir = 0, loop_en = 0.
   - toggle rises at cycle 1.
   - right pulses at cycles 6, 11, 16, 21; step_idx steps 0->1->2->3.
   - done pulses at cycle 21, coincident with the last right pulse; toggle and busy fall at 21.
   - left is never asserted.
2. Left plus loop: dir = 1, loop_en = 1.
   - left pulses every 5 cycles; step_idx wraps 3->0 with no gap and no done pulse.
   - Drop loop_en during step 2: the sequence ends after step 3, done = 1 there.
3. Hold: assert hold for 3 cycles at count = 2 of step 0.
   - First pulse moves from cycle 6 to cycle 9; count and step_idx are frozen throughout the hold.
4. Abort collision: abort asserted on the same cycle as step 1's terminal count.
   - No right pulse and no done pulse; IDLE next cycle; step_idx = 0.
   - A new start works normally afterwards.
5. Reset mid-run: rstb = 0 during step 2.
   - All outputs are 0 on the next edge.
   - start while rstb = 0 is ignored.
   - After release, start launches a fresh sequence from step 0.
6. Ignored inputs:
   - start pulses and dir toggles during RUN do not alter timing or pulse direction.
   - With start held high through completion, toggle shows exactly one low cycle between sequences.
